alu_station: RTL
================

ALU_STATION -- requirements
Module: alu_station

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of station entries (power of 2, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 = tagFree (operand valid).
REQ-004 SHALL have parameter NUM_CDB, default 2, number of broadcast lanes snooped (lane 0 ALU, lane 1 LSBuf).
REQ-005 SHALL have ports: clk  in  1  clock, all state on rising edge; one clock, synchronous active-low reset.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: flush  in  1  misprediction, clears all state.
REQ-008 SHALL have ports: in_valid  in  1 / in_ready  out  1  dispatch handshake.
REQ-009 SHALL have ports: in_op  in  4, in_dest  in  TAG_W, in_tag1/in_tag2  in  TAG_W, in_data1/in_data2  in  DATA_W  dispatched instruction.
REQ-010 SHALL have ports: cdb_valid  in  NUM_CDB, cdb_tag  in  NUM_CDB*TAG_W, cdb_data  in  NUM_CDB*DATA_W  snooped broadcasts, lane i at slice i.
REQ-011 SHALL have ports: out_valid  out  1 / out_ready  in  1  result handshake; out_tag  out  TAG_W; out_data  out  DATA_W.
REQ-012 SHALL have port: count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-013 SHALL assert in_ready iff count < DEPTH; accept when in_valid && in_ready && in_op != NOP; NOP dispatch ignored.
REQ-014 SHALL write accepted instruction into lowest-index free entry, stamped with age (older issued first).
REQ-015 SHALL, on dispatch, capture an operand from any valid CDB lane whose tag equals nonzero in_tagN in the same cycle (bypass), storing tag 0.
REQ-016 SHALL, each cycle, wake every occupied entry whose nonzero operand tag equals a valid lane's tag: load data, set tag 0; lowest lane wins on duplicate tags.
REQ-017 SHALL treat an entry ready when occupied and both tags 0 at the start of the cycle (no same-cycle wake-then-issue).
REQ-018 SHALL issue the oldest ready entry when the output register is empty or out_ready is high, freeing that entry the same edge.
REQ-019 SHALL hold out_valid, out_tag, out_data stable while out_valid && !out_ready.
REQ-020 SHALL have latency 1: entry dispatched ready at edge t -> out_valid high after edge t+1 given no older ready entry and no back-pressure.
REQ-021 SHALL compute: ADD/SUB/JAL modulo 2^DATA_W; SLT signed, SLTU unsigned (result 0/1); SLL/SRL/SRA by data2[clog2(DATA_W)-1:0], SRA sign-filling; XOR/OR/AND bitwise; LUI = data2; undefined op -> 0.
REQ-022 SHALL allow dispatch and issue in the same cycle when full (freed entry not reusable until next cycle; in_ready from current count).
REQ-023 SHALL, on flush, clear all entries, out_valid and count on the next edge; flush dominates dispatch, wake-up and issue.
REQ-024 SHALL keep count = entries occupied, updated +1 dispatch, -1 issue, net 0 when both.

Reset
REQ-025 SHALL, when rst low at a rising edge, clear all entries, out_valid=0, out_tag=0, out_data=0, count=0; in_ready=1 in the following cycle.
REQ-026 SHALL abandon any entry or held result on reset mid-operation; no output pulse after reset release without new dispatch.

Structure
REQ-027 SHALL take op encodings (NOP=0, ADD..JAL), tagFree and op width from shared package alu_pkg.
REQ-028 SHALL place result arithmetic in combinational sub-module alu_exec (op, data1, data2 -> result), parameterised by DATA_W.

Verification
REQ-029 SHALL cover: dispatch ADD dest=3, tags 0, data 5 and 7 -> out_valid next cycle, out_tag=3, out_data=12.
REQ-030 SHALL cover: dispatch SUB dest=2, tag1=5, data2=1; later cdb lane1 tag5 data 10 -> out_data=9 one cycle after broadcast.
REQ-031 SHALL cover: SRA data1=0x80000000, data2=0x24 -> out_data=0xF8000000 (shift 4).
REQ-032 SHALL cover: fill DEPTH=8 with waiting entries -> in_ready=0, count=8; broadcast waking entry 5 then entry 2 -> issue order by age, in_ready=1 after issue.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with two ready entries -> first result held stable, second issued only after handshake.
REQ-034 SHALL cover: flush with 4 entries and out_valid=1 -> next cycle count=0, out_valid=0, pending CDB match ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and tag constants for the ALU reservation station.
package alu_pkg;

   localparam int OP_W     = 4;
   localparam int TAG_FREE = 0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_SLL  = 4'd3,
      OP_SLT  = 4'd4,
      OP_SLTU = 4'd5,
      OP_XOR  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_OR   = 4'd9,
      OP_AND  = 4'd10,
      OP_LUI  = 4'd11,
      OP_JAL  = 4'd12
   } op_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational integer datapath: op, data1, data2 -> result.
module alu_exec
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int SHW = $clog2(DATA_W);

   logic [SHW-1:0] shamt;
   assign shamt = data2_i[SHW-1:0];

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD, OP_JAL: result_o = data1_i + data2_i;
         OP_SUB:         result_o = data1_i - data2_i;
         OP_SLT:         result_o = {{(DATA_W-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
         OP_SLTU:        result_o = {{(DATA_W-1){1'b0}}, data1_i < data2_i};
         OP_SLL:         result_o = data1_i << shamt;
         OP_SRL:         result_o = data1_i >> shamt;
         OP_SRA:         result_o = $signed(data1_i) >>> shamt;
         OP_XOR:         result_o = data1_i ^ data2_i;
         OP_OR:          result_o = data1_i | data2_i;
         OP_AND:         result_o = data1_i & data2_i;
         OP_LUI:         result_o = data2_i;
         default:        result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_station.sv
// ALU reservation station: captures operands from the CDB, issues the oldest
// ready entry into a single registered result slot.
module alu_station
   import alu_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int NUM_CDB = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [OP_W-1:0]             in_op,
   input  logic [TAG_W-1:0]            in_dest,
   input  logic [TAG_W-1:0]            in_tag1,
   input  logic [TAG_W-1:0]            in_tag2,
   input  logic [DATA_W-1:0]           in_data1,
   input  logic [DATA_W-1:0]           in_data2,
   input  logic [NUM_CDB-1:0]          cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [TAG_W-1:0]            out_tag,
   output logic [DATA_W-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int AGE_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [TAG_W-1:0] TAG_0 = TAG_W'(TAG_FREE);

   // age = number of older occupied entries; 0 is the oldest
   typedef struct packed {
      logic              vld;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  dest;
      logic [TAG_W-1:0]  tag1;
      logic [TAG_W-1:0]  tag2;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      logic [AGE_W-1:0]  age;
   } entry_t;

   entry_t             ent_q [DEPTH];
   entry_t             ent_d [DEPTH];
   logic [CNT_W-1:0]   count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;

   logic               iss_any, issue, fr_any, accept;
   logic [IDX_W-1:0]   iss_idx, fr_idx;
   logic [AGE_W-1:0]   best_age;
   logic [OP_W-1:0]    sel_op;
   logic [DATA_W-1:0]  sel_d1, sel_d2, exec_res;

   // Lowest matching lane wins: iterate high to low so lane 0 is written last.
   function automatic logic [DATA_W:0] snoop(
      input logic [TAG_W-1:0]          t,
      input logic [NUM_CDB-1:0]        v,
      input logic [NUM_CDB*TAG_W-1:0]  tg,
      input logic [NUM_CDB*DATA_W-1:0] dt
   );
      logic [DATA_W:0] r;
      r = '0;
      for (int l = NUM_CDB-1; l >= 0; l--) begin
         if (v[l] && (t != TAG_0) && (tg[l*TAG_W +: TAG_W] == t))
            r = {1'b1, dt[l*DATA_W +: DATA_W]};
      end
      return r;
   endfunction

   assign in_ready = (count_q < CNT_W'(DEPTH));

   always_comb begin
      iss_any  = 1'b0;
      iss_idx  = '0;
      best_age = '1;
      fr_any   = 1'b0;
      fr_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].vld && (ent_q[i].tag1 == TAG_0) && (ent_q[i].tag2 == TAG_0) &&
             (!iss_any || (ent_q[i].age < best_age))) begin
            iss_any  = 1'b1;
            iss_idx  = IDX_W'(i);
            best_age = ent_q[i].age;
         end
         if (!ent_q[i].vld && !fr_any) begin
            fr_any = 1'b1;
            fr_idx = IDX_W'(i);
         end
      end
      issue  = iss_any && (!out_valid_q || out_ready);
      accept = in_valid && in_ready && (in_op != OP_NOP) && fr_any;
      sel_op = ent_q[iss_idx].op;
      sel_d1 = ent_q[iss_idx].d1;
      sel_d2 = ent_q[iss_idx].d2;
   end

   alu_exec #(.DATA_W(DATA_W)) u_exec (
      .op_i     (sel_op),
      .data1_i  (sel_d1),
      .data2_i  (sel_d2),
      .result_o (exec_res)
   );

   always_comb begin
      logic [DATA_W:0] s1, s2;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         s1 = snoop(ent_q[i].tag1, cdb_valid, cdb_tag, cdb_data);
         s2 = snoop(ent_q[i].tag2, cdb_valid, cdb_tag, cdb_data);
         if (ent_q[i].vld && s1[DATA_W]) begin
            ent_d[i].tag1 = TAG_0;
            ent_d[i].d1   = s1[DATA_W-1:0];
         end
         if (ent_q[i].vld && s2[DATA_W]) begin
            ent_d[i].tag2 = TAG_0;
            ent_d[i].d2   = s2[DATA_W-1:0];
         end
         // Keep ages dense: everything younger than the issued entry moves up.
         if (issue && ent_q[i].vld && (ent_q[i].age > best_age))
            ent_d[i].age = ent_q[i].age - AGE_W'(1);
         if (issue && (IDX_W'(i) == iss_idx))
            ent_d[i].vld = 1'b0;
      end
      if (accept) begin
         s1 = snoop(in_tag1, cdb_valid, cdb_tag, cdb_data);
         s2 = snoop(in_tag2, cdb_valid, cdb_tag, cdb_data);
         ent_d[fr_idx].vld  = 1'b1;
         ent_d[fr_idx].op   = in_op;
         ent_d[fr_idx].dest = in_dest;
         ent_d[fr_idx].tag1 = s1[DATA_W] ? TAG_0 : in_tag1;
         ent_d[fr_idx].tag2 = s2[DATA_W] ? TAG_0 : in_tag2;
         ent_d[fr_idx].d1   = s1[DATA_W] ? s1[DATA_W-1:0] : in_data1;
         ent_d[fr_idx].d2   = s2[DATA_W] ? s2[DATA_W-1:0] : in_data2;
         ent_d[fr_idx].age  = AGE_W'(count_q - CNT_W'(issue));
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
      if (issue) begin
         out_valid_d = 1'b1;
         out_tag_d   = ent_q[iss_idx].dest;
         out_data_d  = exec_res;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_tag   = out_tag_q;
   assign out_data  = out_data_q;
   assign count     = count_q;

endmodule
